jt900h_muldiv: RTL and testbench
================================

JT900H_MULDIV -- requirements
Module: jt900h_muldiv

Interface
REQ-001 SHALL have parameter W, default 16, full operand width; even, >=8.
REQ-002 SHALL have port rst input 1: synchronous, active-high reset.
REQ-003 SHALL have port clk input 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port cen input 1: clock enable; state advances only when high, except reset.
REQ-005 SHALL have port start input 1: request a new operation.
REQ-006 SHALL have port mode input 2: 0 MUL, 1 MULS, 2 DIV, 3 DIVS.
REQ-007 SHALL have port len input 1: 1 full (N=W), 0 half (N=W/2).
REQ-008 SHALL have port op0 input 2W: dividend (low 2N bits used) or multiplicand (low N bits used).
REQ-009 SHALL have port op1 input W: divisor or multiplier (low N bits used).
REQ-010 SHALL have port busy output 1: operation in progress.
REQ-011 SHALL have port done output 1: one-cen-cycle completion pulse.
REQ-012 SHALL have port rslt output 2W: result, bits above 2N zero.
REQ-013 SHALL have port v output 1: division overflow or divide-by-zero.

Function
REQ-014 SHALL accept start only on a cen cycle with busy=0, including the cycle done=1; it SHALL capture mode, len, op0 and op1 at acceptance, and later operand changes SHALL have no effect.
REQ-015 SHALL ignore start while busy=1, with no queueing.
REQ-016 SHALL hold state when cen=0; held cycles SHALL not count as iterations.
REQ-017 SHALL use states IDLE -> RUN -> IDLE.
  - RUN: one bit per cen cycle, exactly N iterations.
  - busy SHALL be high for exactly N cen cycles after acceptance.
  - On the edge where busy falls, done=1 for one cen cycle and rslt/v become valid.
  - rslt/v SHALL hold until the next accepted start.
REQ-018 SHALL compute MUL as the unsigned shift-add product, rslt[2N-1:0]=op0[N-1:0]*op1[N-1:0], with v=0.
REQ-019 SHALL compute MULS on magnitudes, negate if the operand signs differ, and give a 2N-bit two's-complement product with v=0.
REQ-020 SHALL compute DIV by unsigned restoring division: rslt[N-1:0]=quotient, rslt[2N-1:N]=remainder.
REQ-021 SHALL compute DIVS on magnitudes:
  - quotient negative when the signs differ;
  - remainder sign equals the dividend sign;
  - same field placement as DIV.
REQ-022 SHALL handle divide-by-zero (op1[N-1:0]==0) and magnitude overflow (|dividend high N| >= |divisor|) as an early exit: detected at acceptance, busy for 1 cen cycle, then done=1 and v=1.
REQ-023 SHALL set v=1 after the full N iterations when the DIVS quotient falls outside -2^(N-1)..2^(N-1)-1.
REQ-024 SHALL, whenever v=1, set quotient field = all ones and remainder field = dividend[N-1:0].
REQ-025 SHALL, when start is accepted on a done cycle, pulse done that cycle and set busy=1 on the next cen cycle.

Reset
REQ-026 SHALL apply rst regardless of cen, with priority over start, including in mid-operation.
REQ-027 SHALL, on rst, go to IDLE and set busy=0, done=0, v=0, rslt=0.
REQ-028 SHALL accept start on the first cen cycle after rst deasserts.
REQ-029 SHALL never produce a done pulse for an operation aborted by rst.

Verification
REQ-030 SHALL pass: W=16, DIV, len=1, op0=32'd100000, op1=16'd7 -> busy 16 cen cycles, then done, rslt=32'h0005_37CD, v=0.
REQ-031 SHALL pass: DIVS, len=0, op0=16'hFF9C (-100), op1=8'h07 -> busy 8 cycles, rslt=32'h0000_FEF2 (rem -2, quot -14), v=0.
REQ-032 SHALL pass: DIV, len=1, op0=32'h0001_2345, op1=0 -> busy 1 cycle, v=1, rslt=32'h2345_FFFF.
REQ-033 SHALL pass: MULS, len=1, op0=16'hFFFE, op1=16'h0003 -> rslt=32'hFFFF_FFFA, v=0; MUL with the same operands -> rslt=32'h0002_FFFA.
REQ-034 SHALL pass: rst asserted at iteration 5 of a DIV -> next cycle busy=0, done=0, rslt=0, v=0, no done pulse; a new start then runs normally.
REQ-035 SHALL pass: start pulsed while busy, plus cen toggled 50% during RUN -> extra start ignored; done arrives after exactly N cen-high cycles; result unchanged.

Source files
------------

// File: rtl/jt900h_muldiv.sv
// jt900h_muldiv -- iterative multiply / divide unit, one result bit per
// enabled clock.
//
// Operations (mode): 0 MUL, 1 MULS, 2 DIV, 3 DIVS. len selects the operand
// size N: W (len=1) or W/2 (len=0). Signed operations work on magnitudes and
// fix up the signs on the final iteration. Division is restoring division
// of a 2N-bit dividend by an N-bit divisor. Divide-by-zero and quotients that
// cannot fit in N bits are caught at acceptance and finish after one cycle.
//
// Ports:
//   clk, rst   clock; synchronous active-high reset (ignores cen)
//   cen        clock enable; all non-reset state is held while low
//   start      request a new operation (accepted only when not busy)
//   mode, len  operation and operand size, captured at acceptance
//   op0        dividend (low 2N bits) or multiplicand (low N bits)
//   op1        divisor or multiplier (low N bits)
//   busy       operation in progress (N cycles, or 1 on early exit)
//   done       one-cen-cycle completion pulse
//   rslt       product, or {remainder, quotient}; bits above 2N are zero
//   v          division overflow / divide-by-zero
module jt900h_muldiv #(
  parameter int W = 16
) (
  input  logic           rst,
  input  logic           clk,
  input  logic           cen,
  input  logic           start,
  input  logic [1:0]     mode,
  input  logic           len,
  input  logic [2*W-1:0] op0,
  input  logic [W-1:0]   op1,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] rslt,
  output logic           v
);
  localparam int H  = W / 2;
  localparam int CW = $clog2(W);

  typedef enum logic       {IDLE, RUN} state_t;
  typedef enum logic [1:0] {MUL = 2'd0, MULS = 2'd1, DIV = 2'd2, DIVS = 2'd3} mode_t;

  function automatic logic [W-1:0] mask_n(input logic f);
    return f ? {W{1'b1}} : {{H{1'b0}}, {H{1'b1}}};
  endfunction

  function automatic logic [2*W-1:0] mask_2n(input logic f);
    return f ? {2*W{1'b1}} : {{W{1'b0}}, {W{1'b1}}};
  endfunction

  // Division result layout: remainder above quotient, each N bits wide.
  function automatic logic [2*W-1:0] pack(input logic f, input logic [W-1:0] rem,
                                          input logic [W-1:0] quo);
    return f ? {rem, quo} : {{W{1'b0}}, rem[H-1:0], quo[H-1:0]};
  endfunction

  state_t         state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [2*W-1:0] acc, acc_nx;          // product, or partial remainder
  logic [W-1:0]   opa, opa_nx;          // multiplier / dividend low half, MSB first
  logic [W-1:0]   opb, opb_nx;          // multiplicand / divisor magnitude
  logic [W-1:0]   dlo, dlo_nx;          // raw dividend low half for overflow results
  logic           is_div, is_div_nx, full, full_nx, sgn, sgn_nx;
  logic           neg_q, neg_q_nx, neg_r, neg_r_nx, ovf, ovf_nx;
  logic           done_nx, v_nx;
  logic [2*W-1:0] rslt_nx;

  assign busy = (state == RUN);

  // Operand decode, used only on the acceptance cycle.
  mode_t          m;
  logic           in_div, in_sgn, a_neg, b_neg;
  logic [2*W-1:0] a_msk, a_raw, a_mag;
  logic [W-1:0]   b_raw, b_mag, a_hi, a_lo;

  always_comb begin
    m      = mode_t'(mode);
    in_div = (m == DIV) || (m == DIVS);
    in_sgn = (m == MULS) || (m == DIVS);
    a_msk  = in_div ? mask_2n(len) : {{W{1'b0}}, mask_n(len)};
    a_raw  = op0 & a_msk;
    b_raw  = op1 & mask_n(len);
    a_neg  = in_sgn & (in_div ? (len ? op0[2*W-1] : op0[W-1])
                              : (len ? op0[W-1]   : op0[H-1]));
    b_neg  = in_sgn & (len ? op1[W-1] : op1[H-1]);
    a_mag  = a_neg ? ((-a_raw) & a_msk) : a_raw;
    b_mag  = b_neg ? ((-b_raw) & mask_n(len)) : b_raw;
    a_hi   = len ? a_mag[2*W-1:W] : {{H{1'b0}}, a_mag[W-1:H]};
    a_lo   = a_mag[W-1:0] & mask_n(len);
  end

  // One iteration of either algorithm, plus the sign fix-up for the last one.
  logic           top, ge;
  logic [W:0]     trial;
  logic [W-1:0]   rem_step, opa_step, q_mag, q_out, r_out, lim;
  logic [2*W-1:0] mul_step, prod;
  logic [CW-1:0]  n_last;

  always_comb begin
    top      = full ? opa[W-1] : opa[H-1];
    mul_step = (acc << 1) + (top ? {{W{1'b0}}, opb} : '0);
    trial    = {acc[W-1:0], top};
    ge       = trial >= {1'b0, opb};
    // The remainder stays below the divisor, so W bits always hold it.
    rem_step = ge ? (trial[W-1:0] - opb) : trial[W-1:0];
    opa_step = {opa[W-2:0], is_div & ge};
    q_mag    = opa_step & mask_n(full);
    q_out    = (neg_q ? -q_mag : q_mag) & mask_n(full);
    r_out    = (neg_r ? -rem_step : rem_step) & mask_n(full);
    lim      = full ? {1'b1, {(W-1){1'b0}}} : {{H{1'b0}}, 1'b1, {(H-1){1'b0}}};
    prod     = (neg_q ? -mul_step : mul_step) & mask_2n(full);
    n_last   = full ? CW'(W-1) : CW'(H-1);
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nx  = state;
    cnt_nx    = cnt;
    acc_nx    = acc;
    opa_nx    = opa;
    opb_nx    = opb;
    dlo_nx    = dlo;
    is_div_nx = is_div;
    full_nx   = full;
    sgn_nx    = sgn;
    neg_q_nx  = neg_q;
    neg_r_nx  = neg_r;
    ovf_nx    = ovf;
    done_nx   = 1'b0;
    rslt_nx   = rslt;
    v_nx      = v;
    case (state)
      IDLE: if (start) begin
        state_nx  = RUN;
        cnt_nx    = '0;
        is_div_nx = in_div;
        full_nx   = len;
        sgn_nx    = in_sgn;
        neg_q_nx  = a_neg ^ b_neg;
        neg_r_nx  = a_neg;
        // A high half at or above the divisor means the quotient needs more than N bits.
        ovf_nx    = in_div && ((b_raw == '0) || (a_hi >= b_mag));
        dlo_nx    = op0[W-1:0] & mask_n(len);
        opa_nx    = in_div ? a_lo : b_mag;
        opb_nx    = in_div ? b_mag : a_lo;
        acc_nx    = in_div ? {{W{1'b0}}, a_hi} : '0;
      end
      RUN: begin
        cnt_nx = cnt + CW'(1);
        acc_nx = is_div ? {{W{1'b0}}, rem_step} : mul_step;
        opa_nx = opa_step;
        if (ovf || (cnt == n_last)) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
          if (ovf) begin
            v_nx    = 1'b1;
            rslt_nx = pack(full, dlo, {W{1'b1}});
          end else if (!is_div) begin
            v_nx    = 1'b0;
            rslt_nx = prod;
          end else if (sgn && (neg_q ? (q_mag > lim) : (q_mag >= lim))) begin
            v_nx    = 1'b1;
            rslt_nx = pack(full, dlo, {W{1'b1}});
          end else begin
            v_nx    = 1'b0;
            rslt_nx = pack(full, r_out, q_out);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: there are no memories here, so every register is cleared, keeping rslt/v at 0 after reset.
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opa    <= '0;
      opb    <= '0;
      dlo    <= '0;
      is_div <= 1'b0;
      full   <= 1'b0;
      sgn    <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      ovf    <= 1'b0;
      done   <= 1'b0;
      rslt   <= '0;
      v      <= 1'b0;
    end else if (cen) begin
      // NOTE: non-blocking so every register samples the pre-edge values from the comb block.
      state  <= state_nx;
      cnt    <= cnt_nx;
      acc    <= acc_nx;
      opa    <= opa_nx;
      opb    <= opb_nx;
      dlo    <= dlo_nx;
      is_div <= is_div_nx;
      full   <= full_nx;
      sgn    <= sgn_nx;
      neg_q  <= neg_q_nx;
      neg_r  <= neg_r_nx;
      ovf    <= ovf_nx;
      done   <= done_nx;
      rslt   <= rslt_nx;
      v      <= v_nx;
    end
  end

endmodule

// File: tb/tb_jt900h_muldiv.sv
// tb_jt900h_muldiv -- self-checking bench for jt900h_muldiv (W=16).
// A table of known vectors, hand-written reset-abort and busy-start
// sequences, then randomized operations against an arithmetic model.
module tb_jt900h_muldiv;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst, cen, start, len;
  logic [1:0]     mode;
  logic [2*W-1:0] op0;
  logic [W-1:0]   op1;
  logic           busy, done, v;
  logic [2*W-1:0] rslt;

  int n_cmp = 0;
  int n_bad = 0;
  int cen_mode = 2;   // 0: always high, 1: random, 2: always low

  jt900h_muldiv #(.W(W)) dut (
    .rst(rst), .clk(clk), .cen(cen), .start(start), .mode(mode), .len(len),
    .op0(op0), .op1(op1), .busy(busy), .done(done), .rslt(rslt), .v(v)
  );

  always #5 clk = ~clk;

  initial begin
    cen = 1'b0;
    forever begin
      @(negedge clk);
      case (cen_mode)
        0:       cen = 1'b1;
        1:       cen = 1'($urandom_range(0, 1));
        default: cen = 1'b0;
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Arithmetic reference: results straight from integer math on the operands.
  function automatic void model(input logic [1:0] m, input logic l, input logic [31:0] a,
                                input logic [15:0] b, output logic [31:0] r,
                                output logic vv, output int lat);
    int     n;
    longint one_n, one_2n, ua, ub, sa, sb, abs_a, abs_b, p, q, rm;
    n      = l ? 16 : 8;
    one_n  = longint'(1) << n;
    one_2n = longint'(1) << (2 * n);
    ub     = longint'(b) & (one_n - 1);
    sb     = (ub >= one_n / 2) ? ub - one_n : ub;
    vv     = 1'b0;
    lat    = n;
    q      = 0;
    rm     = 0;
    if (!m[1]) begin
      ua = longint'(a) & (one_n - 1);
      sa = (ua >= one_n / 2) ? ua - one_n : ua;
      p  = m[0] ? sa * sb : ua * ub;
      r  = 32'(p & (one_2n - 1));
    end else begin
      ua = longint'(a) & (one_2n - 1);
      sa = (ua >= one_2n / 2) ? ua - one_2n : ua;
      abs_a = m[0] ? ((sa < 0) ? -sa : sa) : ua;
      abs_b = m[0] ? ((sb < 0) ? -sb : sb) : ub;
      if (ub == 0 || (abs_a / one_n) >= abs_b) begin
        vv  = 1'b1;
        lat = 1;
      end else if (m[0]) begin
        q  = sa / sb;
        rm = sa % sb;
        vv = (q < -(one_n / 2)) || (q >= one_n / 2);
      end else begin
        q  = ua / ub;
        rm = ua % ub;
      end
      if (vv) r = 32'((ua & (one_n - 1)) * one_n + (one_n - 1));
      else    r = 32'((rm & (one_n - 1)) * one_n + (q & (one_n - 1)));
    end
  endfunction

  // Issue one operation, scramble the inputs after acceptance, and count
  // cen-high edges until done. poke re-pulses start while busy.
  task automatic do_op(input logic [1:0] m, input logic l, input logic [31:0] a,
                       input logic [15:0] b, input bit poke,
                       output logic [31:0] r, output logic vo, output int lat);
    int guard;
    @(negedge clk);
    mode = m; len = l; op0 = a; op1 = b; start = 1'b1;
    guard = 0;
    do begin
      @(posedge clk);
      guard++;
    end while (!cen && guard < 100);
    #1;
    start = 1'b0;
    mode  = 2'($urandom);
    len   = 1'($urandom);
    op0   = $urandom;
    op1   = 16'($urandom);
    check("busy after accept", busy, 1);
    lat   = 0;
    guard = 0;
    while (!done && guard < 500) begin
      @(posedge clk);
      if (cen) lat++;
      guard++;
      #1;
      start = poke && !done && (lat == 3);
    end
    start = 1'b0;
    check("done reached", done, 1);
    check("busy low at done", busy, 0);
    r  = rslt;
    vo = v;
  endtask

  typedef struct {
    logic [1:0]  m;
    logic        l;
    logic [31:0] a;
    logic [15:0] b;
    logic [31:0] r;
    logic        v;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [31:0] r, er, a;
    logic        vo, ev, l;
    logic [1:0]  m;
    logic [15:0] b;
    int          lat, elat, seen, g;

    vecs[0]  = '{2'd2, 1'b1, 32'd100000,   16'd7,    32'h000537CD, 1'b0, 16};
    vecs[1]  = '{2'd3, 1'b0, 32'h0000FF9C, 16'h0007, 32'h0000FEF2, 1'b0, 8};
    vecs[2]  = '{2'd2, 1'b1, 32'h00012345, 16'h0000, 32'h2345FFFF, 1'b1, 1};
    vecs[3]  = '{2'd1, 1'b1, 32'h0000FFFE, 16'h0003, 32'hFFFFFFFA, 1'b0, 16};
    vecs[4]  = '{2'd0, 1'b1, 32'h0000FFFE, 16'h0003, 32'h0002FFFA, 1'b0, 16};
    vecs[5]  = '{2'd0, 1'b0, 32'hABCD12FF, 16'h55FF, 32'h0000FE01, 1'b0, 8};
    vecs[6]  = '{2'd1, 1'b0, 32'h00000080, 16'h0080, 32'h00004000, 1'b0, 8};
    vecs[7]  = '{2'd2, 1'b1, 32'h00070000, 16'h0007, 32'h0000FFFF, 1'b1, 1};
    vecs[8]  = '{2'd3, 1'b1, 32'h00008000, 16'h0001, 32'h8000FFFF, 1'b1, 16};
    vecs[9]  = '{2'd3, 1'b1, 32'hFFFF8000, 16'h0001, 32'h00008000, 1'b0, 16};
    vecs[10] = '{2'd3, 1'b0, 32'h00000064, 16'h00F9, 32'h000002F2, 1'b0, 8};
    vecs[11] = '{2'd2, 1'b0, 32'h00001234, 16'hFF00, 32'h000034FF, 1'b1, 1};
    vecs[12] = '{2'd3, 1'b0, 32'h0000FF9C, 16'h00F9, 32'h0000FE0E, 1'b0, 8};

    // Reset with cen held low.
    rst = 1'b1; start = 1'b0; mode = '0; len = 1'b0; op0 = '0; op1 = '0;
    cen_mode = 2;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset rslt", rslt, 0);
    check("reset v", v, 0);
    rst = 1'b0;
    cen_mode = 0;

    // Known vectors, issued back-to-back so each start lands on a done cycle.
    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].m, vecs[i].l, vecs[i].a, vecs[i].b, 1'b0, r, vo, lat);
      check($sformatf("vec%0d rslt", i), r, vecs[i].r);
      check($sformatf("vec%0d v", i), vo, vecs[i].v);
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
    end

    // Reset in the middle of a division: at the fifth iteration, with cen low.
    @(negedge clk);
    mode = 2'd2; len = 1'b1; op0 = 32'd100000; op1 = 16'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    cen_mode = 2;
    @(posedge clk);
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort rslt", rslt, 0);
    check("abort v", v, 0);
    rst = 1'b0;
    cen_mode = 0;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("no done after abort", seen, 0);
    do_op(2'd2, 1'b1, 32'd100000, 16'd7, 1'b0, r, vo, lat);
    check("post-abort rslt", r, 32'h000537CD);
    check("post-abort v", vo, 0);
    check("post-abort latency", lat, 16);

    // Random cen plus a start pulse while busy.
    cen_mode = 1;
    do_op(2'd2, 1'b1, 32'd100000, 16'd7, 1'b1, r, vo, lat);
    check("busy-start rslt", r, 32'h000537CD);
    check("busy-start v", vo, 0);
    check("busy-start latency", lat, 16);
    g = 0;
    do begin
      @(posedge clk);
      g++;
    end while (!cen && g < 100);
    #1;
    check("done lasts one cen cycle", done, 0);

    // Randomized operations against the model.
    for (int i = 0; i < 200; i++) begin
      m = 2'($urandom);
      l = 1'($urandom);
      a = $urandom;
      b = 16'($urandom);
      if (m[1] && $urandom_range(0, 3) != 0) begin
        a = a >> $urandom_range(0, l ? 32 : 16);
        if (m[0] && $urandom_range(0, 1) == 1) a = -a;
      end
      cen_mode = (i % 2 == 1) ? 1 : 0;
      model(m, l, a, b, er, ev, elat);
      do_op(m, l, a, b, (i % 5 == 0), r, vo, lat);
      check($sformatf("rand%0d m%0d l%0d a%0h b%0h rslt", i, m, l, a, b), r, er);
      check($sformatf("rand%0d v", i), vo, ev);
      check($sformatf("rand%0d latency", i), lat, elat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
